sr_frame_loader: RTL
====================

Name: sr_frame_loader

Overview:
- Upstream feeder for the team's bidirectional shift register (bidirec_sr).
- Accepts a parallel MSB-bit word plus a direction flag over a valid/ready handshake.
- Serialises the word onto the shift register's d/en/dir inputs, one bit per enabled cycle.
- After exactly MSB enabled cycles, the shift register's parallel out equals the accepted word. A one-cycle done pulse then marks completion.

Parameters:
- MSB, 8, word width; must match the downstream shift register's MSB.
- GAP, 1, idle cycles (en=0) inserted after done before the next word may be accepted; 0 is legal.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  MSB  word to load.
- in_dir  input  1  direction for this word; driven to the shift register's dir.
- in_valid  input  1  in_data/in_dir valid.
- in_ready  output  1  loader can accept a word; combinational = (state==IDLE) && !hold.
- hold  input  1  downstream stall request; suspends bit issue.
- d  output  1  serial bit to the shift register (registered).
- en  output  1  shift enable to the shift register (registered).
- dir  output  1  shift direction to the shift register (registered).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse, registered; word fully shifted.

Behaviour:
- Reset (reset=0, async, any state):
  - State = IDLE; bit counter = 0; GAP counter = 0; shadow word = 0.
  - d=0, en=0, dir=0, done=0, busy=0.
  - An in-flight word is discarded and no done is produced.
  - After release, in_ready=1 whenever hold=0.
- Shift register convention (fixed):
  - dir=0: the shift register loads d into bit 0 and shifts toward bit MSB-1.
  - dir=1: it loads d into bit MSB-1 and shifts toward bit 0.
  - Bit order follows from this: in_dir=0 sends in_data[MSB-1] first, descending; in_dir=1 sends in_data[0] first, ascending.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Accept on an edge where in_valid && in_ready.
  - On accept: latch in_data to the shadow register; dir<=in_dir; d<=first bit; en<=1; cnt<=0; go to SHIFT.
  - in_valid while in_ready=0 is ignored; the source must hold its word.
- SHIFT, every edge:
  - If en==1, the presented bit is consumed: cnt<=cnt+1.
  - If the consumed count reaches MSB: en<=0, d<=0, done<=1; go to GAP (if GAP>0, gap counter <= GAP) or to IDLE (if GAP=0).
  - Else, if hold==1: en<=0 and d<=next unconsumed bit (presented, not enabled).
  - Else: en<=1, d<=next unconsumed bit.
  - Each bit is therefore presented with en=1 for exactly one cycle; hold never drops or duplicates a bit.
- Holding dir and idle outputs:
  - dir is held constant from accept until the next accept, including through GAP and IDLE.
  - In IDLE and GAP, en=0 and d=0.
- GAP:
  - Decrement the counter each edge, ignoring hold; go to IDLE when it reaches 1.
  - in_ready=0 throughout GAP.
- Done pulse: done is high for exactly one cycle, the cycle after the last en=1 cycle. It is cleared on the next edge.
- Latency:
  - The accept edge produces en=1 in the following cycle.
  - With no hold, en is high for MSB consecutive cycles and done follows immediately.
  - Minimum accept-to-accept spacing is MSB+1+GAP cycles.
- busy is high from the cycle after accept through the last GAP cycle.
- Simultaneous events:
  - hold=1 together with in_valid in IDLE: no accept.
  - hold rising on the same edge the final bit is consumed: completion still occurs (hold only affects unconsumed bits).

Test Plan:
- Reset: reset=0 mid-SHIFT with in_data=8'hC1 → d=0, en=0, done=0 immediately (asynchronous); busy=0. After release no done appears and in_ready=1.
- Direction 0: MSB=8, GAP=1, in_data=8'hC1, in_dir=0, no hold → d sequence 1,1,0,0,0,0,0,1 with en=1 for 8 cycles, then done=1 for 1 cycle, then 1 GAP cycle. Model shift register out=8'hC1.
- Direction 1: in_data=8'hC1, in_dir=1 → d sequence 1,0,0,0,0,0,1,1; dir=1 throughout; model out=8'hC1; done after 8 en cycles.
- Stall: 8'h3C with hold=1 for 3 cycles after the 4th bit → en=0 for exactly 3 cycles with d frozen at bit 4's value. Still exactly 8 en=1 cycles in total; model out=8'h3C.
- Back-to-back: GAP=0, in_valid held high with 8'hFF then 8'h00 → a single en=0 cycle (the done cycle) between words; second accept on the edge after done; 2 done pulses.
- Busy protection: toggle in_data while busy=1 with in_valid=1 → the serialised word is unchanged (the shadow word is used) and the second word is accepted only after in_ready returns to 1.

Source files
------------

// File: rtl/sr_frame_loader.sv
`default_nettype none
// =============================================================================
// Module   : sr_frame_loader
// Purpose  : Serialises a parallel word onto a bidirectional shift register's
//            d/en/dir inputs, then pulses done and observes an idle gap.
// Revision : 1.0
// =============================================================================
module sr_frame_loader #(
  parameter int MSB = 8,
  parameter int GAP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           hold,
  output logic           d,
  output logic           en,
  output logic           dir,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(MSB + 1);
  localparam int IW = (MSB > 1) ? $clog2(MSB) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(MSB);
  localparam logic [GW-1:0] C_GAP  = GW'(GAP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_cons;
  logic [GW-1:0]  r_gap;
  logic [GW-1:0]  w_gap_nxt;
  logic [MSB-1:0] r_shadow;
  logic [MSB-1:0] w_order;
  logic           r_d;
  logic           r_en;
  logic           r_dir;
  logic           r_done;
  logic           w_d_nxt;
  logic           w_en_nxt;
  logic           w_dir_nxt;
  logic           w_done_nxt;
  logic           w_load;
  logic           w_accept;
  logic           w_last;
  logic           w_bit;

  assign in_ready = (r_state == S_IDLE) && !hold;
  assign busy     = (r_state != S_IDLE);
  assign d        = r_d;
  assign en       = r_en;
  assign dir      = r_dir;
  assign done     = r_done;

  assign w_accept = in_valid && in_ready;
  // Bits consumed once this edge retires the currently enabled bit.
  assign w_cons   = r_cnt + CW'(r_en);
  assign w_last   = (w_cons == C_LAST);

  // Reorder the shadow word so index k holds the k-th bit to be sent.
  always_comb begin
    for (int k = 0; k < MSB; k++) begin
      w_order[k] = r_dir ? r_shadow[k] : r_shadow[MSB-1-k];
    end
  end
  assign w_bit = w_order[w_cons[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap <= GW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_d_nxt    = 1'b0;
    w_en_nxt   = 1'b0;
    w_done_nxt = 1'b0;
    w_dir_nxt  = r_dir;
    w_cnt_nxt  = r_cnt;
    w_gap_nxt  = r_gap;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load    = 1'b1;
          w_dir_nxt = in_dir;
          w_d_nxt   = in_dir ? in_data[0] : in_data[MSB-1];
          w_en_nxt  = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        w_cnt_nxt = w_cons;
        if (w_last) begin
          w_done_nxt = 1'b1;
          w_gap_nxt  = C_GAP;
        end else begin
          // A held bit stays presented on d but is not enabled.
          w_d_nxt  = w_bit;
          w_en_nxt = !hold;
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap - GW'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_gap    <= '0;
      r_shadow <= '0;
      r_d      <= 1'b0;
      r_en     <= 1'b0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_gap  <= w_gap_nxt;
      r_d    <= w_d_nxt;
      r_en   <= w_en_nxt;
      r_dir  <= w_dir_nxt;
      r_done <= w_done_nxt;
      if (w_load) begin
        r_shadow <= in_data;
      end
    end
  end

endmodule
`default_nettype wire
